// File: rtl/systolic_array_os_pkg.sv
// sa_pkg: shared types and defaults for the output-stationary systolic array.
//   state_e  : job FSM states (IDLE / LOAD / FLUSH / DRAIN)
//   DEF_*    : default parameter values used by systolic_array_os
//   token_t  : {data, valid} operand token at the default operand width
//   idx_w()  : index width for a count, never below one bit
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_K_MAX  = 256;

  localparam int TOK_DATA_W = DEF_DATA_W;

  // Operand token: data and its valid bit always move together.
  typedef struct packed {
    logic signed [TOK_DATA_W-1:0] data;
    logic                         valid;
  } token_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_array_os_pe.sv
// systolic_pe: one output-stationary processing element.
//   clk, rst           : clock, synchronous active-high reset
//   clr                : synchronous clear of accumulator and forwarding regs (job start)
//   a_in / a_vld_in    : token from the left neighbour (or row skew line)
//   b_in / b_vld_in    : token from the upper neighbour (or column skew line)
//   a_out / a_vld_out  : registered a token forwarded right
//   b_out / b_vld_out  : registered b token forwarded down
//   acc                : running signed accumulator
// The accumulator consumes the registered tokens, so a token entering this PE
// at edge t is accumulated at edge t+1 -- the same registers that forward it.
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic                     a_vld_in,
  input  logic signed [DATA_W-1:0] b_in,
  input  logic                     b_vld_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic                     a_vld_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic                     b_vld_out,
  output logic signed [ACC_W-1:0]  acc
);

  typedef struct packed {
    logic signed [DATA_W-1:0] data;
    logic                     valid;
  } tok_t;

  tok_t a_q, a_d, b_q, b_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  always_comb begin
    a_d   = '{data: a_in, valid: a_vld_in};
    b_d   = '{data: b_in, valid: b_vld_in};
    prod  = $signed(a_q.data) * $signed(b_q.data);
    acc_d = acc_q;
    // Bubbles must never touch the sum, even if their data lanes hold junk.
    // The cast sign-extends the product; the add wraps modulo 2^ACC_W.
    if (a_q.valid && b_q.valid) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign a_out     = a_q.data;
  assign a_vld_out = a_q.valid;
  assign b_out     = b_q.data;
  assign b_vld_out = b_q.valid;
  assign acc       = acc_q;

endmodule

// File: rtl/systolic_array_os.sv
// systolic_array_os: output-stationary ROWS x COLS integer systolic array, C = A*B
// over a run-time accumulation length k_len, with built-in operand skewing.
//   clk, rst            : clock, synchronous active-high reset
//   start, k_len        : job request and its beat count (sampled in IDLE only)
//   busy, done          : job in progress / one-cycle end-of-job pulse
//   in_valid/in_ready   : operand beat handshake; in_a = column k of A, in_b = row k of B
//   out_valid/out_ready : result row handshake; out_row = row index, out_data = C[out_row][*]
// Job flow: IDLE -> LOAD (k_len beats) -> FLUSH (ROWS+COLS-1 cycles) -> DRAIN (ROWS rows).
module systolic_array_os
  import sa_pkg::*;
#(
  parameter int  ROWS   = DEF_ROWS,
  parameter int  COLS   = DEF_COLS,
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  ACC_W  = DEF_ACC_W,
  parameter int  K_MAX  = DEF_K_MAX,
  localparam int K_W    = $clog2(K_MAX + 1),
  localparam int RW     = idx_w(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [K_W-1:0]         k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_a,
  input  logic [COLS*DATA_W-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   done
);

  // Flush counter must reach ROWS+COLS-1 (it ticks once more on the exit cycle).
  localparam int FL_W = $clog2(ROWS + COLS);

  state_e          state_q, state_d;
  logic [K_W-1:0]  klen_q, klen_d;
  logic [K_W-1:0]  beat_q, beat_d, beat_inc;
  logic [FL_W-1:0] flush_q, flush_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;

  logic clr, in_hs, out_hs, last_beat, flush_end, last_row;

  // Grid wiring: a flows right along [i][j], b flows down along [i][j].
  // Column 0 of a_* and row 0 of b_* are driven by the skew lines.
  logic signed [DATA_W-1:0] a_dat [ROWS][COLS+1];
  logic                     a_vld [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_dat [ROWS+1][COLS];
  logic                     b_vld [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc   [ROWS][COLS];

  // -------------------------------------------------------------------------
  // Control decode
  // -------------------------------------------------------------------------
  always_comb begin
    clr       = (state_q == IDLE) && start;
    in_hs     = (state_q == LOAD) && in_valid;
    out_hs    = (state_q == DRAIN) && out_ready;
    beat_inc  = beat_q + K_W'(1);
    last_beat = (beat_inc == klen_q);
    flush_end = (flush_q == FL_W'(ROWS + COLS - 2));
    last_row  = (row_q == RW'(ROWS - 1));
  end

  // -------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (k_len == '0) ? FLUSH : LOAD;
      LOAD:    if (in_hs && last_beat) state_d = FLUSH;
      FLUSH:   if (flush_end) state_d = DRAIN;
      DRAIN:   if (out_hs && last_row) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    out_row   = row_q;
    done      = done_q;
    out_data  = '0;
    for (int j = 0; j < COLS; j++) out_data[j*ACC_W +: ACC_W] = acc[row_q][j];
  end

  // -------------------------------------------------------------------------
  // Beat / flush / drain-row counters
  // -------------------------------------------------------------------------
  always_comb begin
    klen_d  = klen_q;
    beat_d  = beat_q;
    flush_d = flush_q;
    row_d   = row_q;
    done_d  = 1'b0;
    if (clr) begin
      klen_d  = k_len;
      beat_d  = '0;
      flush_d = '0;
      row_d   = '0;
    end
    if (in_hs) beat_d = beat_inc;
    if (state_q == FLUSH) flush_d = flush_q + FL_W'(1);
    if (out_hs) begin
      row_d  = last_row ? '0 : row_q + RW'(1);
      done_d = last_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Input skew: row i delayed by i registers, column j by j registers, so
  // operands of beat k meet in PE(i,j) exactly i+j cycles after acceptance.
  // Outside a handshake the injected token is a bubble (valid=0).
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < ROWS; i++) begin : g_rskew
    if (i == 0) begin : g_pass
      assign a_dat[i][0] = in_a[i*DATA_W +: DATA_W];
      assign a_vld[i][0] = in_hs;
    end else begin : g_sr
      logic signed [DATA_W-1:0] d_q [i];
      logic signed [DATA_W-1:0] d_d [i];
      logic [i-1:0]             v_q, v_d;
      always_comb begin
        d_d    = d_q;
        v_d    = v_q;
        d_d[0] = in_a[i*DATA_W +: DATA_W];
        v_d[0] = in_hs;
        for (int s = 1; s < i; s++) begin
          d_d[s] = d_q[s-1];
          v_d[s] = v_q[s-1];
        end
      end
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          d_q <= '{default: '0};
          v_q <= '0;
        end else begin
          d_q <= d_d;
          v_q <= v_d;
        end
      end
      assign a_dat[i][0] = d_q[i-1];
      assign a_vld[i][0] = v_q[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_cskew
    if (j == 0) begin : g_pass
      assign b_dat[0][j] = in_b[j*DATA_W +: DATA_W];
      assign b_vld[0][j] = in_hs;
    end else begin : g_sr
      logic signed [DATA_W-1:0] d_q [j];
      logic signed [DATA_W-1:0] d_d [j];
      logic [j-1:0]             v_q, v_d;
      always_comb begin
        d_d    = d_q;
        v_d    = v_q;
        d_d[0] = in_b[j*DATA_W +: DATA_W];
        v_d[0] = in_hs;
        for (int s = 1; s < j; s++) begin
          d_d[s] = d_q[s-1];
          v_d[s] = v_q[s-1];
        end
      end
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          d_q <= '{default: '0};
          v_q <= '0;
        end else begin
          d_q <= d_d;
          v_q <= v_d;
        end
      end
      assign b_dat[0][j] = d_q[j-1];
      assign b_vld[0][j] = v_q[j-1];
    end
  end

  // -------------------------------------------------------------------------
  // PE grid
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      systolic_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .a_in      (a_dat[i][j]),
        .a_vld_in  (a_vld[i][j]),
        .b_in      (b_dat[i][j]),
        .b_vld_in  (b_vld[i][j]),
        .a_out     (a_dat[i][j+1]),
        .a_vld_out (a_vld[i][j+1]),
        .b_out     (b_dat[i+1][j]),
        .b_vld_out (b_vld[i+1][j]),
        .acc       (acc[i][j])
      );
    end
  end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed bench for systolic_array_os (4x4, DATA_W=8, ACC_W=16 so signed wrap
// is reachable). Expected rows come from an integer matrix model, are queued
// when a job is launched and are popped by a negedge monitor on each result
// handshake.
module tb_systolic_array_os;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KW   = 9;

  logic                 clk, rst, start, busy, in_valid, in_ready;
  logic                 out_valid, out_ready, done;
  logic [KW-1:0]        k_len;
  logic [ROWS*DW-1:0]   in_a;
  logic [COLS*DW-1:0]   in_b;
  logic [1:0]           out_row;
  logic [COLS*AW-1:0]   out_data;

  systolic_array_os #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ACC_W(AW), .K_MAX(256)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]         row;
    logic [COLS*AW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int nchk = 0;
  int nerr = 0;
  int last_hs = 0;
  int ma [ROWS][256];
  int mb [256][COLS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: a row is consumed at the next edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_row", out_row, e.row);
        chk("out_data", out_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int a, input int b);
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < ROWS; i++) ma[i][k] = a;
      for (int j = 0; j < COLS; j++) mb[k][j] = b;
    end
  endtask

  task automatic push_expected(input int kl);
    for (int i = 0; i < ROWS; i++) begin
      exp_t e;
      e.row  = 2'(i);
      e.data = '0;
      for (int j = 0; j < COLS; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < kl; k++) s += ma[i][k] * mb[k][j];
        e.data[j*AW +: AW] = AW'(s);
      end
      sb.push_back(e);
    end
  endtask

  task automatic start_job(input int kl);
    start = 1'b1;
    k_len = KW'(kl);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 64'(kl != 0));
  endtask

  task automatic feed(input int nbeats, input bit bubbles);
    for (int k = 0; k < nbeats; k++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_a = {ROWS{8'h63}};
        in_b = {COLS{8'h63}};
        tick();
      end
      in_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) in_a[i*DW +: DW] = DW'(ma[i][k]);
      for (int j = 0; j < COLS; j++) in_b[j*DW +: DW] = DW'(mb[k][j]);
      chk("in_ready_load", in_ready, 1);
      tick();
      last_hs = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall_row, input int stall_n, input bit poke,
                       input bit chk_lat);
    int   first_v, done_cyc, left;
    bit   holding, poked;
    logic [1:0]         hold_r;
    logic [COLS*AW-1:0] hold_d;
    first_v = -1; done_cyc = -1; left = stall_n; holding = 0; poked = 0;
    hold_r = '0; hold_d = '0;
    for (int n = 0; n < 200 && done_cyc < 0; n++) begin
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (out_valid && first_v < 0) begin
          first_v = cyc;
          if (chk_lat) chk("first_valid_latency", 64'(cyc - last_hs), ROWS + COLS - 1);
        end
        if (holding) begin
          chk("stall_row_hold", out_row, hold_r);
          chk("stall_data_hold", out_data, hold_d);
        end
        if (left > 0 && out_valid && out_row == 2'(stall_row)) begin
          out_ready = 1'b0; holding = 1; hold_r = out_row; hold_d = out_data; left--;
        end else begin
          out_ready = 1'b1; holding = 0;
        end
        if (poke && out_valid && !poked) begin
          start = 1'b1; k_len = KW'(3); poked = 1;
        end else begin
          start = 1'b0;
        end
        tick();
      end
    end
    start = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 1);
    if (done_cyc >= 0 && first_v >= 0)
      chk("drain_cycles", 64'(done_cyc - first_v), ROWS + stall_n);
    chk("busy_at_done", busy, 0);
    chk("sb_drained", 64'(sb.size()), 0);
    out_ready = 1'b0;
    tick();
    chk("done_single_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic run_job(input int kl, input bit bubbles, input int stall_row,
                         input int stall_n, input bit junk_after);
    push_expected(kl);
    start_job(kl);
    feed(kl, bubbles);
    if (junk_after) begin
      in_valid = 1'b1;
      in_a = {ROWS{8'h7f}};
      in_b = {COLS{8'h7f}};
    end
    drain(stall_row, stall_n, 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_data", out_data, 0);

    // Uniform operands: every element 5*3 = 15.
    fill(5, 3);
    run_job(1, 1'b0, 0, 0, 1'b0);

    // Identity A against B[k][j] = 10k+j gives C[i][j] = 10i+j.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < ROWS; i++) ma[i][k] = (i == k) ? 1 : 0;
      for (int j = 0; j < COLS; j++) mb[k][j] = 10 * k + j;
    end
    run_job(4, 1'b0, 0, 0, 1'b0);

    // Signed wrap at ACC_W=16: 4*16384 -> 0, 3*16384 -> 0xC000.
    fill(-128, -128);
    run_job(4, 1'b0, 0, 0, 1'b0);
    run_job(3, 1'b0, 0, 0, 1'b0);

    // Bubbles with junk data, junk in_valid after LOAD, 5-cycle stall on row 1.
    fill(5, 3);
    run_job(4, 1'b1, 1, 5, 1'b1);

    // Reset in the middle of LOAD, then a clean job.
    fill(9, 9);
    start_job(4);
    feed(2, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    tick();
    fill(2, 7);
    run_job(1, 1'b0, 0, 0, 1'b0);

    // k_len = 0 with a start poked during DRAIN (must be ignored).
    push_expected(0);
    start_job(0);
    drain(0, 0, 1'b1, 1'b0);
    tick();
    chk("post_poke_busy", busy, 0);
    chk("sb_final_empty", 64'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/systolic_array_os.md
# systolic_array_os

Parametrised output-stationary integer systolic array computing C = A·B for a ROWS×COLS tile over a run-time accumulation length k_len. It is the next generation of the fixed-size systolic array, adding:
- parametrised dimensions and widths
- built-in input skewing
- start/done job control
- valid/ready streaming on input and result ports

It sits between the operand buffers and the result writeback path of the accelerator datapath.

## Interface
- ROWS, 4, PE rows (≥1)
- COLS, 4, PE columns (≥1)
- DATA_W, 8, signed operand width
- ACC_W, 32, signed accumulator width; must satisfy ACC_W ≥ 2·DATA_W
- K_MAX, 256, maximum k_len; K_W = $clog2(K_MAX+1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- k_len  in  K_W  beats in this job (0..K_MAX), sampled with start
- busy  out  1  high from the cycle after start until done
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_a  in  ROWS·DATA_W  column k of A; slice i feeds PE row i
- in_b  in  COLS·DATA_W  row k of B; slice j feeds PE column j
- out_valid  out  1  result row valid
- out_ready  in  1  result row consumed when out_valid & out_ready
- out_row  out  $clog2(ROWS) (min 1)  index of presented row
- out_data  out  COLS·ACC_W  C[out_row][0..COLS-1], slice j = column j
- done  out  1  one-cycle pulse at job end

## Operation
FSM states: IDLE, LOAD, FLUSH, DRAIN.
- **IDLE:** start=1 clears all accumulators, latches k_len and sets busy.
  - Next state is LOAD, or FLUSH if k_len=0.
- **LOAD:** in_ready=1.
  - Each accepted beat injects valid tokens into the row/column skew lines.
  - Cycles without a transfer inject invalid tokens (bubbles).
  - After k_len accepted beats, go to FLUSH; in_ready drops the following cycle.
- **FLUSH:** counts ROWS+COLS-1 cycles, then goes to DRAIN.
- **DRAIN:** presents rows 0..ROWS-1 in order.
  - out_row and out_data advance only on handshake.
  - After the row ROWS-1 handshake, go to IDLE with done=1 for one cycle and busy=0.
- **Skew:** row i operand passes through i registers; column j operand passes through j registers.
  - Data and valid bits travel together.
- **PE(i,j):**
  - Forwards a right and b down, each through one register.
  - Adds sign-extended a·b to its accumulator only when both incoming tokens are valid.
- **Arithmetic:** signed two's complement; product of width 2·DATA_W sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W with no saturation.
- start outside IDLE is ignored.
- in_valid outside LOAD is ignored (in_ready=0).
- out_ready outside DRAIN is ignored.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, and all accumulators, skew data and valid bits are cleared.
- **Reset mid-operation:** abandons the job at that edge. done is not pulsed, and no partial results are presented.
- **Start:** start high at edge t gives busy=1 and in_ready=1 from t+1.
- **Accumulation timing:** a beat accepted at edge t updates PE(i,j) at edge t+1+i+j.
  - The last update lands within FLUSH.
  - The first out_valid is asserted exactly ROWS+COLS-1 cycles after the last input handshake.
- **Backpressure:** while out_valid=1 and out_ready=0, out_row and out_data hold stable.
- **Throughput:**
  - With out_ready held high, one row per cycle and total drain of ROWS cycles.
  - With in_valid held high, one beat per cycle.
- **k_len=0:** FLUSH then DRAIN of all-zero rows, then done.
- **Next job:** start may be asserted in the done cycle's following IDLE cycle. There is no overlap between jobs.

## Structure
- Shared package sa_pkg holds:
  - the state enum (IDLE/LOAD/FLUSH/DRAIN)
  - default parameter constants
  - a token struct {data, valid} parametrised via DATA_W localparams, in the same spirit as Scalar
- Sub-module systolic_pe: one PE with registered a/b forwarding, token valid gating and the accumulator, plus a synchronous clear input driven on start and rst.
- Top module holds:
  - skew shift registers
  - FSM, beat counter, flush counter and drain row counter
  - generate grid of ROWS×COLS systolic_pe

## Test plan
- **Uniform operands (default 4×4):** k_len=1, all in_a=5, all in_b=3, out_ready=1 → rows 0..3 each with all elements 15, consecutive cycles, then done pulse.
- **Identity:** k_len=4, A=I, B[k][j]=10k+j → C[i][j]=10i+j; first out_valid exactly 7 cycles after the last input beat.
- **Signed wrap:** DATA_W=8, ACC_W=16, a=b=-128, k_len=4 → 4·16384 wraps to 0. Same operands with k_len=3 → -16384 (0xC000).
- **Bubbles and backpressure:** in_valid alternating 1/0 and out_ready low 5 cycles during row 1 → results identical to the uniform-operands case, out_data and out_row stable while stalled, single done.
- **Reset mid-LOAD:** rst after 2 of 4 beats, then a fresh job with k_len=1, a=2, b=7 → all results 14 with no residue; busy, in_ready and out_valid are 0 the cycle after rst.
- **k_len=0 and ignored start:** k_len=0 → four zero rows, then done. start pulsed during DRAIN → ignored, state returns to IDLE.
